// File: rtl/gpio_bank.sv
// gpio_bank: parametrised GPIO controller on the striVe peripheral bus.
//
// Per-pin output data / output enable, synchronised input readback and
// per-pin rising/falling edge interrupts with write-1-to-clear status.
//
// Ports:
//   clk          system clock
//   resetn       asynchronous active-low reset
//   iomem_valid  bus request (address decode done outside this block)
//   iomem_ready  one-cycle acknowledge
//   iomem_wstrb  byte write strobes, 0 = read
//   iomem_addr   byte offset, [4:2] selects the register
//   iomem_wdata  write data
//   iomem_rdata  read data, nonzero only while iomem_ready is high
//   gpio_in      raw asynchronous pad inputs
//   gpio_out     pad output data
//   gpio_oeb     pad output enable, active low
//   irq          level interrupt, OR of all status bits
//
// Register map: 0x00 OUT, 0x04 OEB, 0x08 IN (RO), 0x0C RISE_EN,
//               0x10 FALL_EN, 0x14 STATUS (W1C), 0x18/0x1C reserved.
module gpio_bank #(
    parameter int               NPINS       = 16,
    parameter int               SYNC_STAGES = 2,
    parameter logic [NPINS-1:0] OEB_RESET   = {NPINS{1'b1}}
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             iomem_valid,
    output logic             iomem_ready,
    input  logic [3:0]       iomem_wstrb,
    input  logic [4:0]       iomem_addr,
    input  logic [31:0]      iomem_wdata,
    output logic [31:0]      iomem_rdata,
    input  logic [NPINS-1:0] gpio_in,
    output logic [NPINS-1:0] gpio_out,
    output logic [NPINS-1:0] gpio_oeb,
    output logic             irq
);

    localparam logic [2:0] SEL_OUT    = 3'd0;
    localparam logic [2:0] SEL_OEB    = 3'd1;
    localparam logic [2:0] SEL_IN     = 3'd2;
    localparam logic [2:0] SEL_RISE   = 3'd3;
    localparam logic [2:0] SEL_FALL   = 3'd4;
    localparam logic [2:0] SEL_STATUS = 3'd5;

    localparam int CHAIN_W = SYNC_STAGES * NPINS;

    logic [NPINS-1:0]   out_q,     out_d;
    logic [NPINS-1:0]   oeb_q,     oeb_d;
    logic [NPINS-1:0]   rise_en_q, rise_en_d;
    logic [NPINS-1:0]   fall_en_q, fall_en_d;
    logic [NPINS-1:0]   status_q,  status_d;
    logic [NPINS-1:0]   prev_q,    prev_d;
    logic [CHAIN_W-1:0] sync_q,    sync_d;
    logic               ready_q,   ready_d;
    logic [31:0]        rdata_q,   rdata_d;

    logic [31:0]        wmask;
    logic [NPINS-1:0]   wr_bits;
    logic [NPINS-1:0]   keep_bits;
    logic [NPINS-1:0]   sync_last;
    logic [NPINS-1:0]   edge_set;
    logic [NPINS-1:0]   status_clr;
    logic [NPINS-1:0]   rd_val;
    logic [31:0]        rd_ext;
    logic [2:0]         sel;
    logic               access;
    logic               is_write;

    // Address bits [1:0] and write-data bits above NPINS carry no state.
    logic unused_bits;
    assign unused_bits = ^{iomem_addr[1:0], iomem_wdata};

    // Expand byte strobes into a bit mask.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wmask[gi*8 +: 8] = {8{iomem_wstrb[gi]}};
        end
    endgenerate

    always_comb begin
        out_d      = out_q;
        oeb_d      = oeb_q;
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        status_clr = '0;
        rd_val     = '0;
        rd_ext     = '0;

        access    = iomem_valid && !ready_q;
        is_write  = |iomem_wstrb;
        sel       = iomem_addr[4:2];
        wr_bits   = iomem_wdata[NPINS-1:0] & wmask[NPINS-1:0];
        keep_bits = ~wmask[NPINS-1:0];

        // Newest sample enters at the bottom, oldest stage sits at the top.
        sync_d    = {sync_q[CHAIN_W-NPINS-1:0], gpio_in};
        sync_last = sync_q[CHAIN_W-1 -: NPINS];
        prev_d    = sync_last;

        edge_set  = (sync_last & ~prev_q & rise_en_q)
                  | (~sync_last & prev_q & fall_en_q);

        case (sel)
            SEL_OUT:    rd_val = out_q;
            SEL_OEB:    rd_val = oeb_q;
            SEL_IN:     rd_val = sync_last;
            SEL_RISE:   rd_val = rise_en_q;
            SEL_FALL:   rd_val = fall_en_q;
            SEL_STATUS: rd_val = status_q;
            default:    rd_val = '0;
        endcase
        rd_ext[NPINS-1:0] = rd_val;

        if (access && is_write) begin
            case (sel)
                SEL_OUT:    out_d      = (out_q     & keep_bits) | wr_bits;
                SEL_OEB:    oeb_d      = (oeb_q     & keep_bits) | wr_bits;
                SEL_RISE:   rise_en_d  = (rise_en_q & keep_bits) | wr_bits;
                SEL_FALL:   fall_en_d  = (fall_en_q & keep_bits) | wr_bits;
                SEL_STATUS: status_clr = wr_bits;
                default:    ;
            endcase
        end

        // A new edge on the same cycle as its clear keeps the bit set.
        status_d = (status_q & ~status_clr) | edge_set;

        ready_d = access;
        rdata_d = (access && !is_write) ? rd_ext : 32'd0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_q     <= '0;
            oeb_q     <= OEB_RESET;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            sync_q    <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            out_q     <= out_d;
            oeb_q     <= oeb_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= prev_d;
            sync_q    <= sync_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign gpio_out    = out_q;
    assign gpio_oeb    = oeb_q;
    assign irq         = |status_q;

endmodule
